// File: rtl/led_pwm_bank.sv
// led_pwm_bank: CHANNELS LED outputs driven from one shared prescaled PWM
// timebase. Each channel can be off, on, PWM duty, blink or breathing.
// Configuration writes land in per-channel shadow registers and are applied
// only on a PWM period wrap, so an LED waveform never glitches mid-period.
// Build option: define LED_ACTIVE_LOW_EN for an inverted (active-low) o_led.

// Per-channel lane: shadow/active config, blink state and the output flop.
module led_pwm_lane #(
  parameter int PWM_BITS = 8,
  parameter bit INV      = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_hit,
  input  logic [2:0]          i_wr_mode,
  input  logic [PWM_BITS-1:0] i_wr_value,
  input  logic                i_wrap,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic [PWM_BITS-1:0] i_breath,
  output logic                o_led
);
  localparam logic [2:0] M_ON     = 3'd1;
  localparam logic [2:0] M_PWM    = 3'd2;
  localparam logic [2:0] M_BLINK  = 3'd3;
  localparam logic [2:0] M_BREATH = 3'd4;

  logic [2:0]          r_sh_mode, r_mode;
  logic [PWM_BITS-1:0] r_sh_val, r_val, r_bcnt;
  logic                r_pend, r_phase, r_led;
  logic                w_lit;

  // Shadow capture; the last write before a wrap wins
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sh_mode <= '0;
      r_sh_val  <= '0;
    end else if (i_wr_hit) begin
      r_sh_mode <= i_wr_mode;
      r_sh_val  <= i_wr_value;
    end
  end

  // Boundary apply; a write on the wrap cycle itself stays pending for the next wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend <= 1'b0;
      r_mode <= '0;
      r_val  <= '0;
    end else begin
      if (i_wrap && r_pend) begin
        r_mode <= r_sh_mode;
        r_val  <= r_sh_val;
      end
      if (i_wr_hit)    r_pend <= 1'b1;
      else if (i_wrap) r_pend <= 1'b0;
    end
  end

  // Blink half-period counter: value+1 periods per phase, restarted on apply
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (i_wrap) begin
      if (r_pend) begin
        r_bcnt  <= '0;
        r_phase <= 1'b0;
      end else if (r_mode == M_BLINK) begin
        if (r_bcnt == r_val) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

  // Mode decode; codes 0 and 5..7 leave the LED dark
  always_comb begin
    w_lit = 1'b0;
    case (r_mode)
      M_ON:     w_lit = 1'b1;
      M_PWM:    w_lit = (i_pwm_cnt < r_val);
      M_BLINK:  w_lit = r_phase;
      M_BREATH: w_lit = (i_pwm_cnt < i_breath);
      default:  w_lit = 1'b0;
    endcase
  end

  // Registered pin drive, polarity applied here so reset matches the dark level
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_led <= INV;
    else         r_led <= w_lit ^ INV;
  end

  assign o_led = r_led;
endmodule

module led_pwm_bank #(
  parameter  int CHANNELS      = 8,
  parameter  int PWM_BITS      = 8,
  parameter  int PRESCALE_BITS = 16,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [PRESCALE_BITS-1:0] i_prescale,
  input  logic                     i_wr_en,
  input  logic [CH_W-1:0]          i_wr_ch,
  input  logic [2:0]               i_wr_mode,
  input  logic [PWM_BITS-1:0]      i_wr_value,
  output logic                     o_wr_ack,
  output logic                     o_wr_err,
  output logic                     o_period_start,
  output logic [CHANNELS-1:0]      o_led
);
`ifdef LED_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  localparam logic [PWM_BITS-1:0] PMAX = '1;
  localparam logic [PWM_BITS-1:0] PONE = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [CH_W:0]       NCH  = (CH_W+1)'(CHANNELS);

  logic [PRESCALE_BITS-1:0] r_presc;
  logic [PWM_BITS-1:0]      r_pwm, r_breath;
  logic                     r_dir_dn, r_ack, r_err, r_ps;
  logic                     w_tick, w_wrap, w_in_range;
  logic [CHANNELS-1:0]      w_hit;

  assign w_tick     = (r_presc == i_prescale);
  assign w_wrap     = w_tick && (r_pwm == PMAX);
  assign w_in_range = ({1'b0, i_wr_ch} < NCH);

  // Prescaler: equality compare only, so lowering i_prescale below the count
  // lets it run up through its natural overflow
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // PWM counter, free-running over 2^PWM_BITS ticks
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_pwm <= '0;
    else if (w_tick) r_pwm <= r_pwm + 1'b1;
  end

  // Breath triangle: turn around on arrival so each endpoint lasts one period
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_breath <= '0;
      r_dir_dn <= 1'b0;
    end else if (w_wrap) begin
      if (!r_dir_dn) begin
        r_breath <= r_breath + 1'b1;
        if (r_breath == PMAX - 1'b1) r_dir_dn <= 1'b1;
      end else begin
        r_breath <= r_breath - 1'b1;
        if (r_breath == PONE) r_dir_dn <= 1'b0;
      end
    end
  end

  // Write handshake and period marker pulses
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_ps  <= 1'b0;
    end else begin
      r_ack <= i_wr_en && w_in_range;
      r_err <= i_wr_en && !w_in_range;
      r_ps  <= w_wrap;
    end
  end

  assign o_wr_ack       = r_ack;
  assign o_wr_err       = r_err;
  assign o_period_start = r_ps;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign w_hit[g] = i_wr_en && w_in_range && (i_wr_ch == CH_W'(g));

    led_pwm_lane #(
      .PWM_BITS (PWM_BITS),
      .INV      (INV)
    ) u_lane (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_wr_hit   (w_hit[g]),
      .i_wr_mode  (i_wr_mode),
      .i_wr_value (i_wr_value),
      .i_wrap     (w_wrap),
      .i_pwm_cnt  (r_pwm),
      .i_breath   (r_breath),
      .o_led      (o_led[g])
    );
  end
endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank. Main instance uses defaults (8 ch, 8-bit
// PWM). A second 6-channel, 4-bit PWM instance covers the reject path (a
// 3-bit channel field cannot encode 8 on an 8-channel part) and a full
// breath triangle inside a short run.
module tb_led_pwm_bank;
  logic clk;
  logic rst;
  logic [15:0] presc;
  logic wr_en;
  logic [2:0] wr_ch, wr_mode;
  logic [7:0] wr_val;
  logic ack, err, ps;
  logic [7:0] led;

  logic [15:0] presc2;
  logic d2_en;
  logic [2:0] d2_ch, d2_mode;
  logic [3:0] d2_val;
  logic d2_ack, d2_err, d2_ps;
  logic [5:0] d2_led;

  int total = 0;
  int bad = 0;

  led_pwm_bank dut (
    .i_clk(clk), .i_reset(rst), .i_prescale(presc), .i_wr_en(wr_en),
    .i_wr_ch(wr_ch), .i_wr_mode(wr_mode), .i_wr_value(wr_val),
    .o_wr_ack(ack), .o_wr_err(err), .o_period_start(ps), .o_led(led)
  );

  led_pwm_bank #(.CHANNELS(6), .PWM_BITS(4), .PRESCALE_BITS(16)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_prescale(presc2), .i_wr_en(d2_en),
    .i_wr_ch(d2_ch), .i_wr_mode(d2_mode), .i_wr_value(d2_val),
    .o_wr_ack(d2_ack), .o_wr_err(d2_err), .o_period_start(d2_ps), .o_led(d2_led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [2:0] m, input logic [7:0] v);
    wr_en = 1'b1; wr_ch = ch; wr_mode = m; wr_val = v;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic d2_write(input logic [2:0] ch, input logic [2:0] m, input logic [3:0] v);
    d2_en = 1'b1; d2_ch = ch; d2_mode = m; d2_val = v;
    cyc();
    d2_en = 1'b0;
  endtask

  task automatic wait_ps();
    bit found = 0;
    for (int i = 0; i < 4096 && !found; i++) begin
      cyc();
      if (ps === 1'b1) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL wait_ps: period_start got none want pulse within 4096 clocks"); end
  endtask

  task automatic wait_ps2();
    bit found = 0;
    for (int i = 0; i < 256 && !found; i++) begin
      cyc();
      if (d2_ps === 1'b1) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL wait_ps2: period_start got none want pulse within 256 clocks"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; presc = '0; presc2 = '0;
    wr_en = 0; wr_ch = 0; wr_mode = 0; wr_val = 0;
    d2_en = 0; d2_ch = 0; d2_mode = 0; d2_val = 0;
    cyc(); cyc();
    total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led: got %h want 00", led); end
    total++; if (ps !== 1'b0) begin bad++; $display("FAIL reset_ps: got %b want 0", ps); end
    total++; if (ack !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b%b want 00", ack, err); end
    total++; if (d2_led !== 6'h00) begin bad++; $display("FAIL reset_led2: got %h want 00", d2_led); end
    rst = 1'b0;
  endtask

  task automatic test_pwm_duty();
    logic [7:0] vals [3];
    int hi;
    vals[0] = 8'd64; vals[1] = 8'd0; vals[2] = 8'd255;
    for (int k = 0; k < 3; k++) begin
      do_write(3'd0, 3'd2, vals[k]);
      total++; if (ack !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL duty_ack[%0d]: ack/err got %b/%b want 1/0", k, ack, err); end
      wait_ps();
      hi = 0;
      for (int i = 0; i < 256; i++) begin cyc(); if (led[0] === 1'b1) hi++; end
      total++; if (hi != int'(vals[k])) begin bad++; $display("FAIL duty_count[%0d]: high clocks got %0d want %0d", k, hi, vals[k]); end
    end
  endtask

  task automatic test_prescale();
    int hi, hi_first, ps_cnt, ps_last;
    presc = 16'd3;
    do_write(3'd0, 3'd2, 8'd128);
    wait_ps();
    hi = 0; hi_first = 0; ps_cnt = 0; ps_last = 0;
    for (int i = 1; i <= 1024; i++) begin
      cyc();
      if (led[0] === 1'b1) begin hi++; if (i <= 512) hi_first++; end
      if (ps === 1'b1) begin ps_cnt++; ps_last = i; end
    end
    total++; if (ps_cnt != 1 || ps_last != 1024) begin bad++; $display("FAIL presc_period: pulses %0d at %0d want 1 at 1024", ps_cnt, ps_last); end
    total++; if (hi != 512) begin bad++; $display("FAIL presc_high: got %0d want 512", hi); end
    total++; if (hi_first != 512) begin bad++; $display("FAIL presc_contig: first-half high got %0d want 512", hi_first); end
    presc = 16'd0;
  endtask

  task automatic test_blink();
    int hi [3];
    do_write(3'd1, 3'd3, 8'd2);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL blink_ack: got %b want 1", ack); end
    wait_ps();
    for (int w = 0; w < 3; w++) begin
      hi[w] = 0;
      for (int i = 0; i < 768; i++) begin cyc(); if (led[1] === 1'b1) hi[w]++; end
    end
    total++; if (hi[0] != 0) begin bad++; $display("FAIL blink_w0: high got %0d want 0", hi[0]); end
    total++; if (hi[1] != 768) begin bad++; $display("FAIL blink_w1: high got %0d want 768", hi[1]); end
    total++; if (hi[2] != 0) begin bad++; $display("FAIL blink_w2: high got %0d want 0", hi[2]); end
  endtask

  task automatic test_shadow();
    int early, hi;
    bit found;
    repeat (100) cyc();
    do_write(3'd2, 3'd1, 8'd0);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL shadow_ack: got %b want 1", ack); end
    early = 0; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc();
      if (ps === 1'b1) found = 1;
      else if (led[2] !== 1'b0) early++;
    end
    total++; if (!found) begin bad++; $display("FAIL shadow_wait: period_start got none want pulse"); end
    total++; if (early != 0 || led[2] !== 1'b0) begin bad++; $display("FAIL shadow_early: early highs %0d led2 %b want 0 0", early, led[2]); end
    cyc();
    total++; if (led[2] !== 1'b1) begin bad++; $display("FAIL shadow_apply: led2 got %b want 1", led[2]); end

    do_write(3'd2, 3'd0, 8'd0);
    wait_ps(); cyc();
    total++; if (led[2] !== 1'b0) begin bad++; $display("FAIL shadow_off: led2 got %b want 0", led[2]); end
    do_write(3'd2, 3'd1, 8'd0);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_ack0: got %b want 1", ack); end
    do_write(3'd2, 3'd0, 8'd0);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1: got %b want 1", ack); end
    wait_ps();
    hi = 0;
    for (int i = 0; i < 256; i++) begin cyc(); if (led[2] === 1'b1) hi++; end
    total++; if (hi != 0) begin bad++; $display("FAIL b2b_last_wins: high got %0d want 0", hi); end

    // now sitting just after a wrap edge; land a write on the next wrap edge
    repeat (255) cyc();
    do_write(3'd2, 3'd1, 8'd0);
    total++; if (ps !== 1'b1 || ack !== 1'b1) begin bad++; $display("FAIL coinc_align: ps/ack got %b/%b want 1/1", ps, ack); end
    hi = 0;
    for (int i = 0; i < 256; i++) begin cyc(); if (led[2] === 1'b1) hi++; end
    total++; if (hi != 0) begin bad++; $display("FAIL coinc_defer: high got %0d want 0", hi); end
    total++; if (ps !== 1'b1) begin bad++; $display("FAIL coinc_ps: got %b want 1", ps); end
    cyc();
    total++; if (led[2] !== 1'b1) begin bad++; $display("FAIL coinc_apply: led2 got %b want 1", led[2]); end
  endtask

  task automatic test_err();
    d2_write(3'd7, 3'd1, 4'd0);
    total++; if (d2_err !== 1'b1 || d2_ack !== 1'b0) begin bad++; $display("FAIL err_ch7: err/ack got %b/%b want 1/0", d2_err, d2_ack); end
    d2_write(3'd6, 3'd1, 4'd0);
    total++; if (d2_err !== 1'b1 || d2_ack !== 1'b0) begin bad++; $display("FAIL err_ch6: err/ack got %b/%b want 1/0", d2_err, d2_ack); end
    cyc();
    total++; if (d2_err !== 1'b0) begin bad++; $display("FAIL err_pulse: err got %b want 0", d2_err); end
    wait_ps2(); cyc();
    total++; if (d2_led !== 6'h00) begin bad++; $display("FAIL err_noeffect: led got %h want 00", d2_led); end
    d2_write(3'd4, 3'd1, 4'd0);
    total++; if (d2_ack !== 1'b1 || d2_err !== 1'b0) begin bad++; $display("FAIL err_ch4_ok: ack/err got %b/%b want 1/0", d2_ack, d2_err); end
    wait_ps2(); cyc();
    total++; if (d2_led !== 6'h10) begin bad++; $display("FAIL err_ch4_led: led got %h want 10", d2_led); end
  endtask

  task automatic test_reset_midrun();
    total++; if (led[2] !== 1'b1) begin bad++; $display("FAIL pre_reset: led2 got %b want 1", led[2]); end
    #3 rst = 1'b1;
    #1;
    total++; if (led !== 8'h00 || ps !== 1'b0) begin bad++; $display("FAIL async_reset: led/ps got %h/%b want 00/0", led, ps); end
    cyc();
    rst = 1'b0;
    do_write(3'd3, 3'd1, 8'd0);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL discard_ack: got %b want 1", ack); end
    repeat (20) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_ps(); cyc();
    total++; if (led !== 8'h00) begin bad++; $display("FAIL discard_pending: led got %h want 00", led); end
  endtask

  task automatic test_breath();
    int hi, exp;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    d2_write(3'd5, 3'd4, 4'd9);
    total++; if (d2_ack !== 1'b1) begin bad++; $display("FAIL breath_ack: got %b want 1", d2_ack); end
    wait_ps2();
    for (int p = 1; p <= 32; p++) begin
      hi = 0;
      for (int i = 0; i < 16; i++) begin cyc(); if (d2_led[5] === 1'b1) hi++; end
      exp = (p <= 15) ? p : ((p <= 30) ? 30 - p : p - 30);
      total++; if (hi != exp) begin bad++; $display("FAIL breath_p%0d: high got %0d want %0d", p, hi, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_pwm_duty();
    test_prescale();
    test_blink();
    test_shadow();
    test_err();
    test_reset_midrun();
    test_breath();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
